// File: rtl/bsg_then_ready_link_serial_mux.sv
// Round-robin serializer: shares one narrow then_ready link among els_p wide channels.
// Each frame is a header flit carrying the channel id, followed by the word LSB-first.
module bsg_then_ready_link_serial_mux #(
  parameter int els_p          = 4,
  parameter int wide_width_p   = 64,
  parameter int narrow_width_p = 16,
  localparam int flits_lp      = (wide_width_p + narrow_width_p - 1) / narrow_width_p,
  localparam int id_width_lp   = (els_p == 1) ? 1 : $clog2(els_p),
  localparam int cnt_width_lp  = (flits_lp == 1) ? 1 : $clog2(flits_lp),
  localparam int word_width_lp = flits_lp * narrow_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [els_p-1:0]                wide_v_i,
  input  logic [els_p*wide_width_p-1:0]   wide_data_i,
  output logic [els_p-1:0]                wide_then_ready_o,
  output logic                            narrow_v_o,
  output logic [narrow_width_p-1:0]       narrow_data_o,
  input  logic                            narrow_then_ready_i,
  output logic [id_width_lp-1:0]          grant_id_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(flits_lp - 1);
  localparam logic [id_width_lp-1:0]  id_last_lp  = id_width_lp'(els_p - 1);

  state_e                   state_r;
  logic [id_width_lp-1:0]   last_r;
  logic [id_width_lp-1:0]   id_r;
  logic [word_width_lp-1:0] word_r;
  logic [cnt_width_lp-1:0]  cnt_r;

  logic [wide_width_p-1:0]  wide_words [els_p];
  logic [id_width_lp-1:0]   grant_idx;
  logic [id_width_lp-1:0]   cand_idx;
  logic [word_width_lp-1:0] grant_word;
  logic                     any_v;
  logic                     found;
  logic                     last_flit_accept;
  logic                     grant_event;

  for (genvar gi = 0; gi < els_p; gi++) begin : g_unpack
    assign wide_words[gi] = wide_data_i[gi*wide_width_p +: wide_width_p];
  end

  assign any_v = |wide_v_i;

  // First valid channel scanning upward from the one after the last grant.
  always_comb begin
    grant_idx = '0;
    cand_idx  = '0;
    found     = 1'b0;
    for (int i = 1; i <= els_p; i++) begin
      cand_idx = id_width_lp'((int'(last_r) + i) % els_p);
      if (!found && wide_v_i[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign last_flit_accept = (state_r == DATA) && narrow_then_ready_i && (cnt_r == cnt_last_lp);
  // Gated by reset so the consume strobe stays low while the link is held in reset.
  assign grant_event = reset_n_i && found && ((state_r == IDLE) || last_flit_accept);

  always_comb begin
    wide_then_ready_o = '0;
    if (grant_event) begin
      wide_then_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    grant_word = '0;
    grant_word[wide_width_p-1:0] = wide_words[grant_idx];
  end

  // Narrow side is decoded purely from registers, so ready never reaches it.
  always_comb begin
    narrow_data_o = '0;
    case (state_r)
      HDR:     narrow_data_o[id_width_lp-1:0] = id_r;
      DATA:    narrow_data_o = word_r[cnt_r*narrow_width_p +: narrow_width_p];
      default: narrow_data_o = '0;
    endcase
  end

  assign narrow_v_o = (state_r != IDLE);
  assign grant_id_o = id_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      last_r  <= id_last_lp;
      word_r  <= '0;
      id_r    <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_event) begin
            word_r  <= grant_word;
            id_r    <= grant_idx;
            last_r  <= grant_idx;
            state_r <= HDR;
          end
        end
        HDR: begin
          if (narrow_then_ready_i) begin
            cnt_r   <= '0;
            state_r <= DATA;
          end
        end
        DATA: begin
          if (narrow_then_ready_i) begin
            if (cnt_r != cnt_last_lp) begin
              cnt_r <= cnt_r + 1'b1;
            end else if (grant_event) begin
              word_r  <= grant_word;
              id_r    <= grant_idx;
              last_r  <= grant_idx;
              state_r <= HDR;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_then_ready_link_serial_mux.sv
// Scoreboard bench: sources feed per-channel queues, a negedge monitor predicts grants
// and flits from round-robin distance and compares against the narrow link.
module tb_bsg_then_ready_link_serial_mux;

  localparam int ELS = 4;
  localparam int WW  = 64;
  localparam int NW  = 16;
  localparam int FL  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ELS-1:0]    wide_v = '0;
  logic [ELS*WW-1:0] wide_data = '0;
  logic [ELS-1:0]    wide_tr;
  logic              nv;
  logic [NW-1:0]     nd;
  logic              ready = 1'b0;
  logic [1:0]        gid;

  logic [3:0]        p_v = '0;
  logic [159:0]      p_data = '0;
  logic [3:0]        p_tr;
  logic              p_nv;
  logic [15:0]       p_nd;
  logic              p_ready = 1'b0;
  logic [1:0]        p_gid;

  always #5 clk = ~clk;

  bsg_then_ready_link_serial_mux #(.els_p(ELS), .wide_width_p(WW), .narrow_width_p(NW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .wide_v_i(wide_v), .wide_data_i(wide_data),
    .wide_then_ready_o(wide_tr), .narrow_v_o(nv), .narrow_data_o(nd),
    .narrow_then_ready_i(ready), .grant_id_o(gid));

  bsg_then_ready_link_serial_mux #(.els_p(4), .wide_width_p(40), .narrow_width_p(16)) dut_pad (
    .clk_i(clk), .reset_n_i(rst_n), .wide_v_i(p_v), .wide_data_i(p_data),
    .wide_then_ready_o(p_tr), .narrow_v_o(p_nv), .narrow_data_o(p_nd),
    .narrow_then_ready_i(p_ready), .grant_id_o(p_gid));

  int n_checks = 0;
  int n_fail   = 0;
  bit bp_mode  = 1'b0;

  logic [WW-1:0] src_q [ELS][$];
  logic [NW-1:0] exp_q [$];
  logic [NW-1:0] acc_log [$];
  int            dut_grants [$];
  int            grant_at [$];
  int            model_last = ELS - 1;
  int            cur_id = 0;
  logic [15:0]   pad_flits [$];
  logic [3:0]    pad_tr_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model
  always @(negedge clk) begin
    int g;
    int best;
    int d;
    bit free;
    bit hs;
    logic [ELS-1:0] exp_tr;
    logic [WW-1:0] w;
    if (rst_n) begin
      hs   = (exp_q.size() != 0) && ready;
      free = (exp_q.size() == 0) || (exp_q.size() == 1 && ready);
      check("narrow_v", 64'(nv), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("narrow_data", 64'(nd), 64'(exp_q[0]));
        check("grant_id", 64'(gid), 64'(cur_id));
      end
      if (nv && ready) acc_log.push_back(nd);
      if (hs) void'(exp_q.pop_front());
      g = -1;
      best = ELS;
      if (free) begin
        for (int k = 0; k < ELS; k++) begin
          if (wide_v[k]) begin
            d = (k - model_last - 1 + 2*ELS) % ELS;
            if (d < best) begin
              best = d;
              g = k;
            end
          end
        end
      end
      exp_tr = (g >= 0) ? ELS'(1 << g) : '0;
      check("wide_then_ready", 64'(wide_tr), 64'(exp_tr));
      for (int k = 0; k < ELS; k++) begin
        if (wide_tr[k]) begin
          dut_grants.push_back(k);
          grant_at.push_back(acc_log.size());
        end
      end
      if (g >= 0) begin
        w = src_q[g][0];
        exp_q.push_back(NW'(g));
        for (int f = 0; f < FL; f++) exp_q.push_back(w[f*NW +: NW]);
        void'(src_q[g].pop_front());
        model_last = g;
        cur_id = g;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (p_tr != 0) pad_tr_log.push_back(p_tr);
      if (p_nv && p_ready) pad_flits.push_back(p_nd);
    end
  end

  task automatic drive_inputs();
    for (int k = 0; k < ELS; k++) begin
      wide_v[k] = (src_q[k].size() != 0);
      wide_data[k*WW +: WW] = wide_v[k] ? src_q[k][0] : '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_mode) ready = ($urandom_range(0, 9) < 3);
    drive_inputs();
  endtask

  task automatic clear_model();
    for (int k = 0; k < ELS; k++) src_q[k].delete();
    exp_q.delete();
    acc_log.delete();
    dut_grants.delete();
    grant_at.delete();
    model_last = ELS - 1;
    cur_id = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    ready = 1'b1;
    wide_v = '1;
    wide_data = '1;
    #1;
    check("rst_wide_tr", 64'(wide_tr), 64'h0);
    check("rst_narrow_v", 64'(nv), 64'h0);
    check("rst_narrow_data", 64'(nd), 64'h0);
    check("rst_grant_id", 64'(gid), 64'h0);
    ready = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    bit busy;
    busy = 1'b1;
    while (busy && cyc < budget) begin
      step();
      cyc++;
      busy = (exp_q.size() != 0);
      for (int k = 0; k < ELS; k++) if (src_q[k].size() != 0) busy = 1'b1;
    end
    check("drain_timeout", 64'(cyc < budget), 64'h1);
    check("idle_after_drain", 64'(nv), 64'h0);
  endtask

  initial begin
    logic [NW-1:0] single_exp [5];
    logic [15:0]   pad_exp [4];
    int            fair_exp [6];
    logic [WW-1:0] w3;
    int            cyc;

    single_exp = '{16'h0002, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    pad_exp    = '{16'h0001, 16'h0123, 16'hCDEF, 16'h00AB};
    fair_exp   = '{0, 1, 2, 3, 0, 1};

    // Single frame on ch2, plus the padded 40-bit instance on ch1
    do_reset();
    ready = 1'b1;
    src_q[2].push_back(64'h1111_2222_3333_4444);
    drive_inputs();
    p_ready = 1'b1;
    p_v = 4'b0010;
    p_data[40 +: 40] = 40'hAB_CDEF_0123;
    step();
    p_v = '0;
    drain(40);
    check("single_grants", 64'(dut_grants.size()), 64'd1);
    if (dut_grants.size() >= 1) check("single_grant_id", 64'(dut_grants[0]), 64'd2);
    check("single_flit_count", 64'(acc_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++) check("single_flit", 64'(acc_log[i]), 64'(single_exp[i]));
    check("pad_grants", 64'(pad_tr_log.size()), 64'd1);
    if (pad_tr_log.size() >= 1) check("pad_grant", 64'(pad_tr_log[0]), 64'h2);
    check("pad_flit_count", 64'(pad_flits.size()), 64'd4);
    for (int i = 0; i < 4 && i < pad_flits.size(); i++) check("pad_flit", 64'(pad_flits[i]), 64'(pad_exp[i]));
    check("pad_idle", 64'(p_nv), 64'h0);
    $display("single frame / padding done: %0d flits", acc_log.size());

    // Fairness: every channel requesting from reset
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < ELS; k++) begin
      src_q[k].push_back({$urandom, $urandom});
      src_q[k].push_back({$urandom, $urandom});
    end
    drive_inputs();
    drain(200);
    check("fair_grant_count", 64'(dut_grants.size()), 64'd8);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++) check("fair_order", 64'(dut_grants[i]), 64'(fair_exp[i]));
    check("fair_no_gap", 64'(acc_log.size()), 64'(8 * (FL + 1)));
    $display("fairness done: %0d grants", dut_grants.size());

    // Randomized traffic under heavy backpressure
    do_reset();
    bp_mode = 1'b1;
    for (int i = 0; i < 12; i++) src_q[$urandom_range(0, ELS-1)].push_back({$urandom, $urandom});
    drive_inputs();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) src_q[$urandom_range(0, ELS-1)].push_back({$urandom, $urandom});
      step();
    end
    drain(3000);
    bp_mode = 1'b0;
    $display("backpressure done: %0d frames", dut_grants.size());

    // Reset in DATA with one data flit already accepted
    do_reset();
    ready = 1'b1;
    src_q[1].push_back({$urandom, $urandom});
    drive_inputs();
    cyc = 0;
    while (exp_q.size() != FL - 1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("midreset_reach", 64'(cyc < 20), 64'h1);
    check("midreset_pre_v", 64'(nv), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_v", 64'(nv), 64'h0);
    check("midreset_data", 64'(nd), 64'h0);
    check("midreset_wide_tr", 64'(wide_tr), 64'h0);
    check("midreset_gid", 64'(gid), 64'h0);
    clear_model();
    @(posedge clk);
    #1;
    w3 = {$urandom, $urandom};
    src_q[3].push_back(w3);
    drive_inputs();
    rst_n = 1'b1;
    drain(40);
    check("midreset_flits", 64'(acc_log.size()), 64'd5);
    if (acc_log.size() >= 2) begin
      check("midreset_hdr", 64'(acc_log[0]), 64'h3);
      check("midreset_flit0", 64'(acc_log[1]), 64'(w3[15:0]));
    end
    $display("reset mid-frame done: %0d flits after release", acc_log.size());

    // Late arrival on ch0 during ch1 header
    do_reset();
    ready = 1'b1;
    src_q[1].push_back({$urandom, $urandom});
    drive_inputs();
    cyc = 0;
    while (exp_q.size() != FL + 1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("late_reach_hdr", 64'(cyc < 20), 64'h1);
    src_q[0].push_back({$urandom, $urandom});
    drive_inputs();
    drain(60);
    check("late_grant_count", 64'(dut_grants.size()), 64'd2);
    if (dut_grants.size() >= 2) begin
      check("late_order", 64'(dut_grants[1]), 64'd0);
      check("late_grant_point", 64'(grant_at[1]), 64'(FL + 1));
    end
    $display("late arrival done: %0d grants", dut_grants.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
